seven_segment_scanner: RTL and testbench
========================================

# seven_segment_scanner

Time-multiplexes one shared hex-to-seven-segment decoder across `NUM_DIGITS` common-anode digits. Holds a multi-digit display value, accepts new values through a valid/ready load port, and scans digits round-robin with a blanking gap between digits to prevent ghosting. New values apply only at frame boundaries, so a frame never mixes old and new digits. Sits between the value-producing logic and the board's segment/anode pins.

## Interface
- `NUM_DIGITS`, default 4: number of multiplexed digits, range 2–8.
- `PRESCALE`, default 1000: clock cycles each digit is lit (SHOW), ≥1.
- `BLANK_CYCLES`, default 16: clock cycles with all anodes off before each digit, ≥1.
- `clk` in 1: single clock; all state updates on its rising edge.
- `resetN` in 1: reset is asynchronous and active-low.
- `enable` in 1: scan enable; low forces IDLE.
- `loadValid` in 1: `loadData` valid.
- `loadReady` out 1: block can accept a load.
- `loadData` in 4*NUM_DIGITS: packed nibbles; digit i is `[4i+3:4i]`, digit 0 least significant.
- `digitEnable` in NUM_DIGITS: per-digit mask; a 0 keeps that digit dark during its slot. Sampled live.
- `segment` out 7: active-low segments {A..G}, registered.
- `anode` out NUM_DIGITS: active-low digit selects, one-hot-low or all-high, registered.
- `scanDone` out 1: one-cycle pulse at each completed frame.

## Operation
- Reset values: FSM=IDLE, digit index 0, display register 0, shadow 0, pending 0, `anode`=all 1, `segment`=7'b1111111, `loadReady`=1, `scanDone`=0.
- States: IDLE, BLANK, SHOW.
  - IDLE: anodes off, segments off. `enable`=1 → BLANK at index 0.
  - BLANK: anodes off. Segment register loads the decoded nibble of the current index. Stays BLANK_CYCLES cycles → SHOW.
  - SHOW: `anode[idx]`=0 if `digitEnable[idx]`, else all 1. Stays PRESCALE cycles. On exit, the index increments → BLANK. If the index is NUM_DIGITS-1, it wraps to 0, `scanDone` pulses, and pending shadow (if any) copies into the display register.
  - `enable`=0 in any state → IDLE next cycle, index reset to 0, outputs off. Display register and shadow are retained.
- Load handshake:
  - Transfer occurs when `loadValid && loadReady`. Data goes to the shadow, pending is set, and `loadReady`=0 from the next cycle.
  - Pending is applied at the next frame boundary, or on the next cycle if the FSM is in IDLE. Pending then clears and `loadReady` returns to 1 the following cycle.
  - A transfer in the same cycle as a frame boundary is not applied at that boundary. It waits for the next one.
  - `loadValid` without `loadReady` is ignored. The source must hold its data.
- Decoding: digit nibble → segments, 0–F hex glyphs, active-low.
- Single internal cycle counter, width clog2(max(PRESCALE,BLANK_CYCLES)). It is reloaded on every state entry and never wraps past its terminal count.

## Timing
- Frame length = NUM_DIGITS*(BLANK_CYCLES+PRESCALE) cycles.
- First lit anode: BLANK_CYCLES+1 cycles after the first cycle `enable` is sampled high in IDLE.
- `segment` and `anode` change on the same edge the FSM enters the new state. `segment` settles during BLANK, and `anode` is never low while `segment` changes.
- Worst-case load-to-display latency: one full frame plus BLANK_CYCLES+1.
- Reset assertion mid-frame takes effect immediately: anodes off, with no glitch to a lit state.

## Configuration
- `SEVENSEG_ZERO_BLANK_EN` defined: leading zeros are suppressed. Each digit above the most significant nonzero digit is forced dark, with `anode` all 1 in its SHOW slot. Digit 0 is always shown. This is evaluated on the display register at each frame boundary.
- Undefined: all digits are shown, gated only by `digitEnable`.

## Structure
- Package `sevenSegPkg`: state enum (IDLE/BLANK/SHOW), `SEG_OFF`=7'b1111111 constant, `NIBBLE_W`=4.
- One sub-module: the combinational decoder `sevenSegmentController`, instantiated once and fed by the indexed display nibble.

## Test plan
Bench parameters for all scenarios: NUM_DIGITS=4, PRESCALE=4, BLANK_CYCLES=2.
- Reset then `enable`=1 with display 0x0000 → anode sequence 1110,1101,1011,0111, each low for exactly 4 cycles with 2 dark cycles before each; `segment`=0000001 while lit; `scanDone` pulse every 24 cycles.
- Load 0x1A3F while scanning → `loadReady` low next cycle; the frame in progress still shows the old value; the next frame shows F,3,A,1 on digits 0–3 (`segment` 0111000, 0000110, 0001000, 1001111); `loadReady` high one cycle after the boundary.
- Load asserted on the exact boundary cycle → applied one frame later, not at that boundary.
- `digitEnable`=4'b0101 → anodes 1110 and 1011 lit in their slots; slots 1 and 3 stay 1111 for their full SHOW duration.
- `enable` dropped mid-SHOW of digit 2 → next cycle anode=1111, segment=1111111; re-enable restarts at digit 0 after 2 blank cycles. Also assert `resetN` mid-SHOW → outputs off asynchronously.
- With `SEVENSEG_ZERO_BLANK_EN`, load 0x0070 → only digits 0 and 1 lit. Load 0x0000 → only digit 0 lit. Without the macro → all four digits lit.

Source files
------------

// File: rtl/seven_segment_scanner_pkg.sv
// Shared types and constants for the seven-segment scanner: scan FSM states,
// the all-segments-off pattern and the nibble width.
package sevenSegPkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } scanState_t;

    localparam int         NIBBLE_W = 4;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

endpackage

// File: rtl/seven_segment_scanner_decoder.sv
// Combinational hex-to-seven-segment decoder, active-low segments ordered {A..G}.
module sevenSegmentController
    import sevenSegPkg::*;
(
    input  logic [NIBBLE_W-1:0] i_nibble,
    output logic [6:0]          o_segment
);

    always_comb begin
        o_segment = SEG_OFF;
        case (i_nibble)
            4'h0: o_segment = 7'b0000001;
            4'h1: o_segment = 7'b1001111;
            4'h2: o_segment = 7'b0010010;
            4'h3: o_segment = 7'b0000110;
            4'h4: o_segment = 7'b1001100;
            4'h5: o_segment = 7'b0100100;
            4'h6: o_segment = 7'b0100000;
            4'h7: o_segment = 7'b0001111;
            4'h8: o_segment = 7'b0000000;
            4'h9: o_segment = 7'b0000100;
            4'hA: o_segment = 7'b0001000;
            4'hB: o_segment = 7'b1100000;
            4'hC: o_segment = 7'b0110001;
            4'hD: o_segment = 7'b1000010;
            4'hE: o_segment = 7'b0110000;
            4'hF: o_segment = 7'b0111000;
        endcase
    end

endmodule

// File: rtl/seven_segment_scanner.sv
// Multiplexed common-anode display scanner with blanking gaps and frame-aligned loads.
// Define SEVENSEG_ZERO_BLANK_EN to suppress leading zero digits.
module seven_segment_scanner
    import sevenSegPkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int PRESCALE     = 1000,
    parameter int BLANK_CYCLES = 16
)(
    input  logic                           clk,
    input  logic                           resetN,
    input  logic                           enable,
    input  logic                           loadValid,
    output logic                           loadReady,
    input  logic [NIBBLE_W*NUM_DIGITS-1:0] loadData,
    input  logic [NUM_DIGITS-1:0]          digitEnable,
    output logic [6:0]                     segment,
    output logic [NUM_DIGITS-1:0]          anode,
    output logic                           scanDone
);

    localparam int DATA_W  = NIBBLE_W * NUM_DIGITS;
    localparam int IDX_W   = $clog2(NUM_DIGITS);
    localparam int MAX_CNT = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
    localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

    localparam logic [CNT_W-1:0] SHOW_LOAD  = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);

    scanState_t            r_state;
    scanState_t            w_nextState;
    logic [IDX_W-1:0]      r_idx;
    logic [IDX_W-1:0]      w_nextIdx;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_nextCnt;
    logic [DATA_W-1:0]     r_display;
    logic [DATA_W-1:0]     r_shadow;
    logic [DATA_W-1:0]     w_nextDisplay;
    logic                  r_pending;
    logic                  w_frameWrap;
    logic                  w_applyPending;
    logic                  w_loadFire;
    logic [NIBBLE_W-1:0]   w_nibble;
    logic [6:0]            w_decoded;
    logic [6:0]            w_nextSegment;
    logic [6:0]            r_segment;
    logic [NUM_DIGITS-1:0] w_litMask;
    logic [NUM_DIGITS-1:0] w_nextAnode;
    logic [NUM_DIGITS-1:0] r_anode;
    logic                  r_scanDone;

    always_comb begin
        w_nextState = r_state;
        w_nextIdx   = r_idx;
        w_nextCnt   = r_cnt;
        w_frameWrap = 1'b0;
        if (!enable) begin
            w_nextState = IDLE;
            w_nextIdx   = '0;
            w_nextCnt   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_nextState = BLANK;
                    w_nextIdx   = '0;
                    w_nextCnt   = BLANK_LOAD;
                end
                BLANK: begin
                    if (r_cnt == '0) begin
                        w_nextState = SHOW;
                        w_nextCnt   = SHOW_LOAD;
                    end else begin
                        w_nextCnt = r_cnt - CNT_W'(1);
                    end
                end
                SHOW: begin
                    if (r_cnt == '0) begin
                        w_nextState = BLANK;
                        w_nextCnt   = BLANK_LOAD;
                        if (r_idx == LAST_IDX) begin
                            w_nextIdx   = '0;
                            w_frameWrap = 1'b1;
                        end else begin
                            w_nextIdx = r_idx + IDX_W'(1);
                        end
                    end else begin
                        w_nextCnt = r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    w_nextState = IDLE;
                    w_nextIdx   = '0;
                    w_nextCnt   = '0;
                end
            endcase
        end
    end

    // A load arriving on the boundary cycle sees r_pending low, so it waits a frame.
    assign w_loadFire     = loadValid && !r_pending;
    assign w_applyPending = r_pending && (w_frameWrap || (r_state == IDLE));
    assign w_nextDisplay  = w_applyPending ? r_shadow : r_display;

`ifdef SEVENSEG_ZERO_BLANK_EN
    logic w_seenNonZero;

    always_comb begin
        w_seenNonZero = 1'b0;
        w_litMask     = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_seenNonZero = w_seenNonZero || (r_display[NIBBLE_W*i +: NIBBLE_W] != '0);
            w_litMask[i]  = w_seenNonZero || (i == 0);
        end
    end
`else
    assign w_litMask = '1;
`endif

    // Decode against the upcoming index and display so segments are final on BLANK entry.
    always_comb begin
        w_nibble = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_nextIdx == IDX_W'(i)) begin
                w_nibble = w_nextDisplay[NIBBLE_W*i +: NIBBLE_W];
            end
        end
    end

    sevenSegmentController u_decoder (
        .i_nibble  (w_nibble),
        .o_segment (w_decoded)
    );

    always_comb begin
        w_nextAnode   = '1;
        w_nextSegment = r_segment;
        case (w_nextState)
            IDLE:  w_nextSegment = SEG_OFF;
            BLANK: w_nextSegment = w_decoded;
            SHOW: begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if ((w_nextIdx == IDX_W'(i)) && digitEnable[i] && w_litMask[i]) begin
                        w_nextAnode[i] = 1'b0;
                    end
                end
            end
            default: w_nextSegment = SEG_OFF;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            r_cnt      <= '0;
            r_anode    <= '1;
            r_segment  <= SEG_OFF;
            r_scanDone <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            r_idx      <= w_nextIdx;
            r_cnt      <= w_nextCnt;
            r_anode    <= w_nextAnode;
            r_segment  <= w_nextSegment;
            r_scanDone <= w_frameWrap;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_display <= '0;
            r_shadow  <= '0;
            r_pending <= 1'b0;
        end else begin
            r_display <= w_nextDisplay;
            if (w_loadFire) begin
                r_shadow  <= loadData;
                r_pending <= 1'b1;
            end else if (w_applyPending) begin
                r_pending <= 1'b0;
            end
        end
    end

    assign loadReady = !r_pending;
    assign segment   = r_segment;
    assign anode     = r_anode;
    assign scanDone  = r_scanDone;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Self-checking bench for seven_segment_scanner (4 digits, 4 show cycles, 2 blank cycles).
module tb_seven_segment_scanner;

    localparam int NUM_DIGITS   = 4;
    localparam int PRESCALE     = 4;
    localparam int BLANK_CYCLES = 2;
    localparam int SLOT         = BLANK_CYCLES + PRESCALE;
    localparam int FRAME        = NUM_DIGITS * SLOT;

    logic        clk;
    logic        resetN;
    logic        enable;
    logic        loadValid;
    logic        loadReady;
    logic [15:0] loadData;
    logic [3:0]  digitEnable;
    logic [6:0]  segment;
    logic [3:0]  anode;
    logic        scanDone;

    seven_segment_scanner #(
        .NUM_DIGITS   (NUM_DIGITS),
        .PRESCALE     (PRESCALE),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) dut (
        .clk         (clk),
        .resetN      (resetN),
        .enable      (enable),
        .loadValid   (loadValid),
        .loadReady   (loadReady),
        .loadData    (loadData),
        .digitEnable (digitEnable),
        .segment     (segment),
        .anode       (anode),
        .scanDone    (scanDone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] anode;
        logic [6:0] segment;
        logic       scanDone;
        logic       loadReady;
    } expect_t;

    typedef struct {
        logic [15:0] value;
        logic [3:0]  digEn;
        logic [27:0] segs;
        logic [3:0]  lit;
    } vector_t;

    expect_t sbQueue[$];
    vector_t vectors[7];

    int compared   = 0;
    int mismatched = 0;
    int cycleNo    = 0;

    bit          mRun;
    int          mPos;
    logic [15:0] mDisplay;
    logic [15:0] mShadow;
    bit          mPending;

    int         tDigit;
    logic [3:0] tExpAnode;

    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'h0: return 7'b0000001;
            4'h1: return 7'b1001111;
            4'h2: return 7'b0010010;
            4'h3: return 7'b0000110;
            4'h4: return 7'b1001100;
            4'h5: return 7'b0100100;
            4'h6: return 7'b0100000;
            4'h7: return 7'b0001111;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0000100;
            4'hA: return 7'b0001000;
            4'hB: return 7'b1100000;
            4'hC: return 7'b0110001;
            4'hD: return 7'b1000010;
            4'hE: return 7'b0110000;
            default: return 7'b0111000;
        endcase
    endfunction

    function automatic logic [3:0] litMaskOf(input logic [15:0] d);
        logic [3:0] m;
        m = 4'b1111;
`ifdef SEVENSEG_ZERO_BLANK_EN
        if (d[15:12] != 4'h0)     m = 4'b1111;
        else if (d[11:8] != 4'h0) m = 4'b0111;
        else if (d[7:4] != 4'h0)  m = 4'b0011;
        else                      m = 4'b0001;
`endif
        return m;
    endfunction

    task automatic checkValue(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s at cycle %0d: got %0b, expected %0b", name, cycleNo, actual, expected);
        end
    endtask

    // Spec-level reference: position within the frame decides digit and blank/show phase.
    task automatic modelStep();
        expect_t    e;
        bit         wrap;
        bit         oldRun;
        bit         oldPending;
        int         digit;
        logic [3:0] lit;
        wrap       = 1'b0;
        oldRun     = mRun;
        oldPending = mPending;
        if (!enable) begin
            mRun = 1'b0;
            mPos = 0;
        end else if (!mRun) begin
            mRun = 1'b1;
            mPos = 0;
        end else if (mPos == FRAME - 1) begin
            wrap = 1'b1;
            mPos = 0;
        end else begin
            mPos++;
        end
        if (oldPending && (wrap || !oldRun)) begin
            mDisplay = mShadow;
            mPending = 1'b0;
        end
        if (loadValid && !oldPending) begin
            mShadow  = loadData;
            mPending = 1'b1;
        end
        e.anode     = 4'hF;
        e.segment   = 7'b1111111;
        e.scanDone  = wrap;
        e.loadReady = !mPending;
        if (mRun) begin
            digit     = mPos / SLOT;
            e.segment = glyph(mDisplay[4*digit +: 4]);
            lit       = litMaskOf(mDisplay);
            if (((mPos % SLOT) >= BLANK_CYCLES) && digitEnable[digit] && lit[digit]) begin
                e.anode = ~(4'b0001 << digit);
            end
        end
        sbQueue.push_back(e);
    endtask

    task automatic checkOutput();
        expect_t e;
        if (sbQueue.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL scoreboard empty at cycle %0d: got no entry, expected one", cycleNo);
            return;
        end
        e = sbQueue.pop_front();
        checkValue("anode", 32'(anode), 32'(e.anode));
        checkValue("segment", 32'(segment), 32'(e.segment));
        checkValue("scanDone", 32'(scanDone), 32'(e.scanDone));
        checkValue("loadReady", 32'(loadReady), 32'(e.loadReady));
    endtask

    task automatic applyStimulus();
        modelStep();
        @(posedge clk);
        #1;
        cycleNo++;
        checkOutput();
    endtask

    task automatic runUntilPos(input int target);
        int guard;
        guard = 0;
        while (!(mRun && mPos == target) && guard < 100) begin
            applyStimulus();
            guard++;
        end
        if (!(mRun && mPos == target)) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL runUntilPos timeout: got pos %0d, expected %0d", mPos, target);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before 200000 ns");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        resetN      = 1'b0;
        enable      = 1'b0;
        loadValid   = 1'b0;
        loadData    = 16'h0000;
        digitEnable = 4'hF;
        mRun        = 1'b0;
        mPos        = 0;
        mDisplay    = 16'h0000;
        mShadow     = 16'h0000;
        mPending    = 1'b0;

        vectors[0] = '{value: 16'h0000, digEn: 4'hF,
                       segs: {7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001}, lit: 4'hF};
        vectors[1] = '{value: 16'h1A3F, digEn: 4'hF,
                       segs: {7'b1001111, 7'b0001000, 7'b0000110, 7'b0111000}, lit: 4'hF};
        vectors[2] = '{value: 16'h1A3F, digEn: 4'b0101,
                       segs: {7'b1001111, 7'b0001000, 7'b0000110, 7'b0111000}, lit: 4'b0101};
        vectors[3] = '{value: 16'h0070, digEn: 4'hF,
                       segs: {7'b0000001, 7'b0000001, 7'b0001111, 7'b0000001}, lit: 4'hF};
        vectors[4] = '{value: 16'h9B2D, digEn: 4'b1010,
                       segs: {7'b0000100, 7'b1100000, 7'b0010010, 7'b1000010}, lit: 4'b1010};
        vectors[5] = '{value: 16'h4567, digEn: 4'hF,
                       segs: {7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111}, lit: 4'hF};
        vectors[6] = '{value: 16'h0EC8, digEn: 4'hF,
                       segs: {7'b0000001, 7'b0110000, 7'b0110001, 7'b0000000}, lit: 4'hF};
`ifdef SEVENSEG_ZERO_BLANK_EN
        vectors[0].lit = 4'b0001;
        vectors[3].lit = 4'b0011;
        vectors[6].lit = 4'b0111;
`endif

        repeat (2) @(posedge clk);
        #1;
        checkValue("reset anode", 32'(anode), 32'hF);
        checkValue("reset segment", 32'(segment), 32'h7F);
        checkValue("reset loadReady", 32'(loadReady), 32'h1);
        checkValue("reset scanDone", 32'(scanDone), 32'h0);
        resetN = 1'b1;

        for (int v = 0; v < 7; v++) begin
            enable      = 1'b0;
            loadValid   = 1'b0;
            digitEnable = vectors[v].digEn;
            applyStimulus();
            applyStimulus();
            loadValid = 1'b1;
            loadData  = vectors[v].value;
            applyStimulus();
            loadValid = 1'b0;
            checkValue("table loadReady after load", 32'(loadReady), 32'h0);
            applyStimulus();
            checkValue("table loadReady after idle apply", 32'(loadReady), 32'h1);
            enable = 1'b1;
            for (int c = 0; c <= FRAME; c++) begin
                applyStimulus();
                if (c == FRAME) begin
                    checkValue("table scanDone at frame end", 32'(scanDone), 32'h1);
                end else begin
                    tDigit = c / SLOT;
                    if ((c % SLOT) == BLANK_CYCLES || (c % SLOT) == SLOT - 1) begin
                        tExpAnode = vectors[v].lit[tDigit] ? ~(4'b0001 << tDigit) : 4'hF;
                        checkValue("table anode", 32'(anode), 32'(tExpAnode));
                        checkValue("table segment", 32'(segment), 32'(vectors[v].segs[7*tDigit +: 7]));
                    end else if ((c % SLOT) == 0) begin
                        checkValue("table blank anode", 32'(anode), 32'hF);
                    end
                end
            end
        end

        // Load mid-frame: current frame keeps 0x0EC8, next frame shows 0x1A3F.
        digitEnable = 4'hF;
        runUntilPos(8);
        loadValid = 1'b1;
        loadData  = 16'h1A3F;
        applyStimulus();
        loadValid = 1'b0;
        checkValue("midframe loadReady drops", 32'(loadReady), 32'h0);
        runUntilPos(14);
        checkValue("midframe old digit2 segment", 32'(segment), 32'b0110000);
        runUntilPos(FRAME - 1);
        applyStimulus();
        checkValue("midframe boundary scanDone", 32'(scanDone), 32'h1);
        checkValue("midframe loadReady restored", 32'(loadReady), 32'h1);
        runUntilPos(2);
        checkValue("midframe new digit0 anode", 32'(anode), 32'b1110);
        checkValue("midframe new digit0 segment", 32'(segment), 32'b0111000);
        runUntilPos(20);
        checkValue("midframe new digit3 anode", 32'(anode), 32'b0111);
        checkValue("midframe new digit3 segment", 32'(segment), 32'b1001111);

        // Load on the boundary cycle is deferred by a whole frame.
        runUntilPos(FRAME - 1);
        loadValid = 1'b1;
        loadData  = 16'h4567;
        applyStimulus();
        loadValid = 1'b0;
        checkValue("boundary load scanDone", 32'(scanDone), 32'h1);
        checkValue("boundary load loadReady", 32'(loadReady), 32'h0);
        runUntilPos(2);
        checkValue("boundary load not yet applied", 32'(segment), 32'b0111000);
        runUntilPos(FRAME - 1);
        applyStimulus();
        checkValue("boundary load loadReady restored", 32'(loadReady), 32'h1);
        runUntilPos(2);
        checkValue("boundary load applied segment", 32'(segment), 32'b0001111);
        checkValue("boundary load applied anode", 32'(anode), 32'b1110);

        // Enable dropped during digit 2 SHOW, then restart from digit 0.
        runUntilPos(14);
        enable = 1'b0;
        applyStimulus();
        checkValue("disable anode off", 32'(anode), 32'hF);
        checkValue("disable segment off", 32'(segment), 32'h7F);
        applyStimulus();
        enable = 1'b1;
        applyStimulus();
        applyStimulus();
        checkValue("restart blank anode", 32'(anode), 32'hF);
        applyStimulus();
        checkValue("restart digit0 anode", 32'(anode), 32'b1110);
        checkValue("restart digit0 segment", 32'(segment), 32'b0001111);

        // Asynchronous reset in the middle of a lit slot with a load pending.
        runUntilPos(8);
        loadValid = 1'b1;
        loadData  = 16'h2222;
        applyStimulus();
        loadValid = 1'b0;
        #2;
        resetN = 1'b0;
        #1;
        checkValue("async reset anode", 32'(anode), 32'hF);
        checkValue("async reset segment", 32'(segment), 32'h7F);
        checkValue("async reset loadReady", 32'(loadReady), 32'h1);
        checkValue("async reset scanDone", 32'(scanDone), 32'h0);
        mRun     = 1'b0;
        mPos     = 0;
        mDisplay = 16'h0000;
        mShadow  = 16'h0000;
        mPending = 1'b0;
        enable   = 1'b0;
        #1;
        resetN = 1'b1;
        applyStimulus();
        applyStimulus();
        enable = 1'b1;
        applyStimulus();
        applyStimulus();
        applyStimulus();
        checkValue("post reset digit0 anode", 32'(anode), 32'b1110);
        checkValue("post reset digit0 segment", 32'(segment), 32'b0000001);
        for (int c = 0; c < FRAME; c++) begin
            applyStimulus();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
